// File: rtl/spi_accel_pkg.sv
// rtl/spi_accel_pkg.sv - shared states, address map and command bit positions
package spi_accel_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CMD     = 2'd1,
      DATA_RD = 2'd2,
      DATA_WR = 2'd3
   } spi_state_t;

   localparam logic [5:0] ADDR_DEVID   = 6'h00;
   localparam logic [5:0] WR_LO        = 6'h1D;
   localparam logic [5:0] WR_HI        = 6'h31;
   localparam logic [5:0] ADDR_BW_RATE = 6'h2C;
   localparam logic [5:0] DATA_LO      = 6'h32;
   localparam logic [5:0] DATA_HI      = 6'h37;

   localparam int RW_BIT      = 7;
   localparam int MB_BIT      = 6;
   localparam int NUM_WR      = int'(WR_HI) - int'(WR_LO) + 1;
   localparam int BW_RATE_IDX = int'(ADDR_BW_RATE) - int'(WR_LO);

   function automatic logic is_writable(input logic [5:0] a);
      return (a >= WR_LO) && (a <= WR_HI);
   endfunction

endpackage

// File: rtl/spi_accel_slave_if.sv
// rtl/spi_accel_slave_if.sv - SPI pin bundle between flight master and sensor model
interface spi_accel_slave_if;
   logic sclk;
   logic cs;
   logic sdi;
   logic sdo;
   logic sdo_oe;

   modport master (output sclk, output cs, output sdi, input sdo, input sdo_oe);
   modport slave  (input sclk, input cs, input sdi, output sdo, output sdo_oe);
endinterface

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - synchroniser and edge detector for the SPI pins
module spi_input_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic cs,
   input  logic sdi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic sdi_s
);

   logic [SYNC_STAGES-1:0] sclk_sr;
   logic [SYNC_STAGES-1:0] cs_sr;
   logic [SYNC_STAGES-1:0] sdi_sr;

   // sclk and cs reset to their idle-high levels so release of rst creates no edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sr <= '1;
         cs_sr   <= '1;
         sdi_sr  <= '0;
      end else begin
         sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs};
         sdi_sr  <= {sdi_sr[SYNC_STAGES-2:0], sdi};
      end
   end

   assign sclk_rise = sclk_sr[SYNC_STAGES-2] & ~sclk_sr[SYNC_STAGES-1];
   assign sclk_fall = ~sclk_sr[SYNC_STAGES-2] & sclk_sr[SYNC_STAGES-1];
   assign cs_rise   = cs_sr[SYNC_STAGES-2] & ~cs_sr[SYNC_STAGES-1];
   assign cs_fall   = ~cs_sr[SYNC_STAGES-2] & cs_sr[SYNC_STAGES-1];
   assign sdi_s     = sdi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_accel_slave.sv
// rtl/spi_accel_slave.sv - mode-3 SPI responder emulating a tri-axis accelerometer
module spi_accel_slave
   import spi_accel_pkg::*;
#(
   parameter logic [7:0] DEVID       = 8'hE5,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
   input  logic                clk,
   input  logic                rst,
   spi_accel_slave_if.slave    spi,
   input  logic [15:0]         accel_x,
   input  logic [15:0]         accel_y,
   input  logic [15:0]         accel_z,
   output logic                wr_strobe,
   output logic [5:0]          wr_addr,
   output logic [7:0]          wr_data,
   output logic                frame_active,
   output logic                frame_done
);

   logic sclk_rise, sclk_fall, cs_fall, cs_rise, sdi_s;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .sclk      (spi.sclk),
      .cs        (spi.cs),
      .sdi       (spi.sdi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .sdi_s     (sdi_s)
   );

   spi_state_t state_q, state_d;
   logic [2:0]  bit_cnt;
   logic [6:0]  shift_q;
   logic [7:0]  shift_in;
   logic [5:0]  addr_q;
   logic        mb_q;
   logic        wr_lock;
   logic [7:0]  rd_byte;
   logic [7:0]  rd_data;
   logic [47:0] snap_q;
   logic [7:0]  regs [NUM_WR];
   logic [5:0]  widx;
   logic [5:0]  sidx;

   assign shift_in = {shift_q, sdi_s};
   assign widx     = addr_q - WR_LO;
   assign sidx     = addr_q - DATA_LO;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (cs_rise) begin
         state_d = IDLE;
      end else if (cs_fall) begin
         state_d = CMD;
      end else if (state_q == CMD && sclk_rise && bit_cnt == 3'd0) begin
         state_d = shift_in[RW_BIT] ? DATA_RD : DATA_WR;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      if (addr_q == ADDR_DEVID)
         rd_data = DEVID;
      else if (is_writable(addr_q))
         rd_data = regs[widx[4:0]];
      else if (addr_q >= DATA_LO && addr_q <= DATA_HI)
         rd_data = snap_q[{sidx[2:0], 3'b000} +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt      <= 3'd7;
         shift_q      <= '0;
         addr_q       <= '0;
         mb_q         <= 1'b0;
         wr_lock      <= 1'b0;
         rd_byte      <= '0;
         snap_q       <= '0;
         spi.sdo      <= 1'b0;
         spi.sdo_oe   <= 1'b0;
         wr_strobe    <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         frame_active <= 1'b0;
         frame_done   <= 1'b0;
         for (int i = 0; i < NUM_WR; i++)
            regs[i] <= (i == BW_RATE_IDX) ? BW_RATE_RST : 8'h00;
      end else begin
         wr_strobe  <= 1'b0;
         frame_done <= 1'b0;
         if (cs_fall) begin
            bit_cnt      <= 3'd7;
            shift_q      <= '0;
            wr_lock      <= 1'b0;
            frame_active <= 1'b1;
            snap_q       <= {accel_z, accel_y, accel_x};
         end else if (state_q != IDLE) begin
            if (sclk_rise) begin
               shift_q <= shift_in[6:0];
               bit_cnt <= bit_cnt - 3'd1;
               if (bit_cnt == 3'd0) begin
                  case (state_q)
                     CMD: begin
                        mb_q   <= shift_in[MB_BIT];
                        addr_q <= shift_in[5:0];
                     end
                     DATA_RD: if (mb_q) addr_q <= addr_q + 6'd1;
                     DATA_WR: if (!wr_lock) begin
                        if (is_writable(addr_q)) begin
                           regs[widx[4:0]] <= shift_in;
                           wr_strobe       <= 1'b1;
                           wr_addr         <= addr_q;
                           wr_data         <= shift_in;
                        end
                        if (mb_q) addr_q  <= addr_q + 6'd1;
                        else      wr_lock <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            // first falling edge of each byte latches the byte for the remaining bits
            if (sclk_fall && state_q == DATA_RD) begin
               spi.sdo_oe <= 1'b1;
               if (bit_cnt == 3'd7) begin
                  rd_byte <= rd_data;
                  spi.sdo <= rd_data[7];
               end else begin
                  spi.sdo <= rd_byte[bit_cnt];
               end
            end
         end
         if (cs_rise) begin
            spi.sdo      <= 1'b0;
            spi.sdo_oe   <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_accel_slave.sv
// tb/tb_spi_accel_slave.sv - directed self-checking bench for spi_accel_slave
module tb_spi_accel_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ax, ay, az;
   logic        wr_strobe;
   logic [5:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        frame_active, frame_done;

   int passed = 0;
   int total  = 0;
   int strobe_cnt = 0;
   int done_cnt   = 0;
   logic [5:0] last_waddr = '0;
   logic [7:0] last_wdata = '0;

   spi_accel_slave_if spi();

   spi_accel_slave dut (
      .clk          (clk),
      .rst          (rst),
      .spi          (spi),
      .accel_x      (ax),
      .accel_y      (ay),
      .accel_z      (az),
      .wr_strobe    (wr_strobe),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .frame_active (frame_active),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe) begin
         strobe_cnt = strobe_cnt + 1;
         last_waddr = wr_addr;
         last_wdata = wr_data;
      end
      if (frame_done) done_cnt = done_cnt + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      spi.cs = 1'b0;
      wait_clk(8);
   endtask

   task automatic cs_high();
      wait_clk(8);
      spi.cs = 1'b1;
      wait_clk(12);
   endtask

   task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi.sclk = 1'b0;
         spi.sdi  = mosi[i];
         wait_clk(8);
         miso[i]  = spi.sdo;
         spi.sclk = 1'b1;
         wait_clk(8);
      end
   endtask

   task automatic test_reset();
      wait_clk(3);
      total += 7;
      if (spi.sdo !== 1'b0)        $display("FAIL reset_sdo got %b exp 0", spi.sdo);          else passed++;
      if (spi.sdo_oe !== 1'b0)     $display("FAIL reset_sdo_oe got %b exp 0", spi.sdo_oe);    else passed++;
      if (wr_strobe !== 1'b0)      $display("FAIL reset_wr_strobe got %b exp 0", wr_strobe); else passed++;
      if (wr_addr !== 6'h00)       $display("FAIL reset_wr_addr got %h exp 00", wr_addr);     else passed++;
      if (wr_data !== 8'h00)       $display("FAIL reset_wr_data got %h exp 00", wr_data);     else passed++;
      if (frame_active !== 1'b0)   $display("FAIL reset_frame_active got %b exp 0", frame_active); else passed++;
      if (frame_done !== 1'b0)     $display("FAIL reset_frame_done got %b exp 0", frame_done);     else passed++;
      rst = 1'b0;
      wait_clk(4);
   endtask

   task automatic test_devid_read();
      logic [7:0] b;
      int d0;
      d0 = done_cnt;
      cs_low();
      total++;
      if (frame_active !== 1'b1) $display("FAIL devid_frame_active got %b exp 1", frame_active); else passed++;
      xfer(8'h80, 8, b);
      xfer(8'h00, 8, b);
      total += 2;
      if (b !== 8'hE5) $display("FAIL devid_data got %h exp e5", b); else passed++;
      if (spi.sdo_oe !== 1'b1) $display("FAIL devid_sdo_oe got %b exp 1", spi.sdo_oe); else passed++;
      cs_high();
      total += 3;
      if (done_cnt - d0 !== 1)   $display("FAIL devid_frame_done got %0d exp 1", done_cnt - d0); else passed++;
      if (frame_active !== 1'b0) $display("FAIL devid_frame_idle got %b exp 0", frame_active);   else passed++;
      if (spi.sdo_oe !== 1'b0)   $display("FAIL devid_sdo_oe_idle got %b exp 0", spi.sdo_oe);    else passed++;
   endtask

   task automatic test_burst_read();
      logic [7:0] b;
      logic [7:0] exp_b [6];
      exp_b = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h0F, 8'h0F};
      ax = 16'h1234; ay = 16'hABCD; az = 16'h0F0F;
      cs_low();
      xfer(8'hF2, 8, b);
      ax = 16'h5555; ay = 16'h6666; az = 16'h7777;
      for (int k = 0; k < 6; k++) begin
         xfer(8'h00, 8, b);
         total++;
         if (b !== exp_b[k]) $display("FAIL burst_byte%0d got %h exp %h", k, b, exp_b[k]); else passed++;
      end
      cs_high();
   endtask

   task automatic test_write_readback();
      logic [7:0] b;
      int s0;
      s0 = strobe_cnt;
      cs_low();
      xfer(8'h2D, 8, b);
      xfer(8'h08, 8, b);
      cs_high();
      total += 3;
      if (strobe_cnt - s0 !== 1) $display("FAIL wr_strobe_count got %0d exp 1", strobe_cnt - s0); else passed++;
      if (last_waddr !== 6'h2D)  $display("FAIL wr_addr got %h exp 2d", last_waddr);            else passed++;
      if (last_wdata !== 8'h08)  $display("FAIL wr_data got %h exp 08", last_wdata);            else passed++;
      cs_low();
      xfer(8'hAD, 8, b);
      for (int k = 0; k < 2; k++) begin
         xfer(8'h00, 8, b);
         total++;
         if (b !== 8'h08) $display("FAIL readback_byte%0d got %h exp 08", k, b); else passed++;
      end
      cs_high();
   endtask

   task automatic test_single_write_lock();
      logic [7:0] b;
      int s0;
      s0 = strobe_cnt;
      cs_low();
      xfer(8'h1E, 8, b);
      xfer(8'h11, 8, b);
      xfer(8'h22, 8, b);
      cs_high();
      total += 2;
      if (strobe_cnt - s0 !== 1) $display("FAIL nomb_strobe_count got %0d exp 1", strobe_cnt - s0); else passed++;
      if (last_wdata !== 8'h11)  $display("FAIL nomb_wr_data got %h exp 11", last_wdata);          else passed++;
   endtask

   task automatic test_readonly_write();
      logic [7:0] b;
      int s0;
      s0 = strobe_cnt;
      cs_low();
      xfer(8'h00, 8, b);
      xfer(8'h55, 8, b);
      cs_high();
      total++;
      if (strobe_cnt - s0 !== 0) $display("FAIL ro_strobe_count got %0d exp 0", strobe_cnt - s0); else passed++;
      cs_low();
      xfer(8'h80, 8, b);
      xfer(8'h00, 8, b);
      cs_high();
      total++;
      if (b !== 8'hE5) $display("FAIL ro_devid got %h exp e5", b); else passed++;
   endtask

   task automatic test_abort_wrap();
      logic [7:0] b;
      int s0;
      s0 = strobe_cnt;
      cs_low();
      xfer(8'h2C, 8, b);
      xfer(8'h33, 4, b);
      cs_high();
      total++;
      if (strobe_cnt - s0 !== 0) $display("FAIL abort_strobe_count got %0d exp 0", strobe_cnt - s0); else passed++;
      cs_low();
      xfer(8'hAC, 8, b);
      xfer(8'h00, 8, b);
      cs_high();
      total++;
      if (b !== 8'h0A) $display("FAIL abort_bw_rate got %h exp 0a", b); else passed++;
      cs_low();
      xfer(8'hFF, 8, b);
      xfer(8'h00, 8, b);
      total++;
      if (b !== 8'h00) $display("FAIL wrap_addr3f got %h exp 00", b); else passed++;
      xfer(8'h00, 8, b);
      total++;
      if (b !== 8'hE5) $display("FAIL wrap_addr00 got %h exp e5", b); else passed++;
      cs_high();
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      cs_low();
      xfer(8'h80, 8, b);
      xfer(8'h00, 4, b);
      total++;
      if (spi.sdo_oe !== 1'b1) $display("FAIL midrst_pre_oe got %b exp 1", spi.sdo_oe); else passed++;
      rst = 1'b1;
      #1;
      total += 3;
      if (spi.sdo !== 1'b0)      $display("FAIL midrst_sdo got %b exp 0", spi.sdo);          else passed++;
      if (spi.sdo_oe !== 1'b0)   $display("FAIL midrst_sdo_oe got %b exp 0", spi.sdo_oe);    else passed++;
      if (frame_active !== 1'b0) $display("FAIL midrst_frame_active got %b exp 0", frame_active); else passed++;
      spi.cs = 1'b1;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(4);
      cs_low();
      xfer(8'h80, 8, b);
      xfer(8'h00, 8, b);
      cs_high();
      total++;
      if (b !== 8'hE5) $display("FAIL midrst_devid got %h exp e5", b); else passed++;
   endtask

   initial begin
      spi.sclk = 1'b1;
      spi.cs   = 1'b1;
      spi.sdi  = 1'b0;
      ax = 16'h0; ay = 16'h0; az = 16'h0;
      test_reset();
      test_devid_read();
      test_burst_read();
      test_write_readback();
      test_single_write_lock();
      test_readonly_write();
      test_abort_wrap();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/spi_accel_slave.md
Name: spi_accel_slave

Overview:
SPI responder that models the tri-axis accelerometer register interface seen by the flight-side SPI master. It is used in simulation and hardware-in-loop builds to stand in for the physical sensor. The block decodes command frames (R/W, multi-byte, 6-bit address) and serves reads from a 64-byte register map. The map holds DEVID, host-writable configuration registers and a coherent snapshot of X/Y/Z samples. It accepts writes to the configuration range and reports them to the host.

Parameters:
DEVID, 8'hE5, value returned at address 0x00
SYNC_STAGES, 2, flip-flop stages on sclk/cs/sdi before edge detection
BW_RATE_RST, 8'h0A, reset value of register 0x2C

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous active-high reset
sclk  input  1  SPI clock from master, idles high (mode 3)
cs  input  1  chip select, active low
sdi  input  1  master-to-slave serial data
sdo  output  1  slave-to-master serial data
sdo_oe  output  1  high while slave drives sdo
accel_x  input  16  X sample, two's complement
accel_y  input  16  Y sample
accel_z  input  16  Z sample
wr_strobe  output  1  one-cycle pulse per accepted register write
wr_addr  output  6  address of accepted write
wr_data  output  8  data of accepted write
frame_active  output  1  high between cs fall and cs rise (synchronised)
frame_done  output  1  one-cycle pulse on synchronised cs rise

Behaviour:
- Reset values: sdo=0, sdo_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, frame_active=0, frame_done=0. State goes to IDLE. Writable registers go to 0x00, except 0x2C which goes to BW_RATE_RST.
- sclk, cs and sdi each pass through SYNC_STAGES flops; edges are detected from the last two stages. Supported when sclk period >= 8 clk.
- Mode 3 timing: sample sdi on a detected sclk rising edge; update sdo on a detected sclk falling edge; MSB first.
- States are IDLE, CMD, DATA_RD and DATA_WR.
- IDLE -> CMD on cs fall. On that fall: bit_cnt=7, frame_active=1, and accel_x/y/z are latched into a snapshot at 0x32..0x37 (LSB at the even address). The snapshot is unchanged until the next cs fall.
- CMD: shift in 8 bits. Bit7 is R/W (1=read), bit6 is MB, bits5:0 are the address. After the 8th rising edge go to DATA_RD if R/W=1, else DATA_WR.
- DATA_RD: on each falling edge sdo_oe=1 and sdo=rd_byte[bit_cnt]. rd_byte is loaded from the current address before its first bit is driven.
- DATA_RD address handling: after 8 bits, address increments if MB=1, wrapping 0x3F->0x00. If MB=0 the same address repeats.
- DATA_WR: shift in 8 bits. After the 8th rising edge, if the address is in 0x1D..0x31, update the register and pulse wr_strobe/wr_addr/wr_data for exactly one clk. Writes to other addresses are silently dropped with no strobe.
- DATA_WR address handling: MB=1 increments the address per byte with wrap. MB=0 accepts only the first byte and ignores the rest.
- Read map: 0x00 returns DEVID; 0x1D..0x31 return register contents; 0x32..0x37 return the snapshot; all other addresses read 0x00.
- cs rise in any state: return to IDLE; sdo_oe=0, sdo=0; frame_active=0; pulse frame_done for one clk. A partial byte is discarded with no write.
- cs rise coinciding with a completing 8th write edge: the write commits, then the frame closes.
- sclk edges while cs is high are ignored.
- Async rst mid-frame: all outputs return to reset values immediately. The next cs fall starts a clean frame.
- Latency: sdo is valid no later than SYNC_STAGES+2 clk after the master's sclk fall.

Decomposition:
- Package spi_accel_pkg holds: the state enum; address constants (ADDR_DEVID=0x00, WR_LO=0x1D, WR_HI=0x31, ADDR_BW_RATE=0x2C, DATA_LO=0x32, DATA_HI=0x37); and the R/W and MB bit positions.
- Sub-module spi_input_sync: parameterised synchroniser plus edge detector, producing sclk_rise, sclk_fall, cs_fall, cs_rise and sdi_s.

Test Plan:
- DEVID read: frame cmd 0x80 then 8 clocks -> sdo shifts 0xE5; frame_done pulses once after cs rise.
- Burst read: x=0x1234, y=0xABCD, z=0x0F0F, cmd 0xF2, 48 data clocks; accel inputs changed mid-frame -> bytes 0x34,0x12,0xCD,0xAB,0x0F,0x0F.
- Write then readback: cmd 0x2D, data 0x08 -> one wr_strobe, wr_addr=0x2D, wr_data=0x08; then read cmd 0xAD returns 0x08.
- Read-only write: cmd 0x00, data 0x55 -> no wr_strobe; subsequent DEVID read returns 0xE5.
- Abort and wrap: write cmd 0x2C, cs rises after 4 data bits -> no strobe, 0x2C still 0x0A. Then MB read cmd 0xFF for 16 clocks -> 0x00, 0xE5.
- Reset mid-frame: assert rst during DATA_RD -> sdo=0, sdo_oe=0, frame_active=0; next 0x80 frame returns 0xE5.
